// File: rtl/mul_div_unit.sv
// Iterative integer multiply/divide unit for RV64M/RV32M-style opcodes.
// Fixed-latency multiply, restoring divide at one quotient bit per cycle, valid/ready result hand-off.
module mul_div_unit #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 3
) (
  input  logic            i_clk,
  input  logic            i_arstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_alu_control,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_MULH   = 5'b10000;
  localparam logic [4:0] OP_MULHSU = 5'b10001;
  localparam logic [4:0] OP_MULHU  = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b10011;
  localparam logic [4:0] OP_DIVU   = 5'b10100;
  localparam logic [4:0] OP_REM    = 5'b10101;
  localparam logic [4:0] OP_REMU   = 5'b10110;
  localparam logic [4:0] OP_MULW   = 5'b10111;
  localparam logic [4:0] OP_DIVW   = 5'b11000;
  localparam logic [4:0] OP_DIVUW  = 5'b11001;
  localparam logic [4:0] OP_REMW   = 5'b11010;
  localparam logic [4:0] OP_REMUW  = 5'b11011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic            W_OK       = 1'(XLEN > 32);
  localparam logic            MUL_SINGLE = 1'(MUL_CYCLES == 1);
  localparam logic [6:0]      MUL_INIT   = 7'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);
  localparam logic [6:0]      DIV_CNT_X  = 7'(XLEN - 1);
  localparam logic [6:0]      DIV_CNT_W  = 7'd31;
  localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] mul_calc(input logic [4:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ea;
    logic [2*XLEN-1:0] eb;
    logic [2*XLEN-1:0] p;
    logic [31:0]       pw;
    logic              a_sg;
    logic              b_sg;
    a_sg = (op == OP_MULH) || (op == OP_MULHSU);
    b_sg = (op == OP_MULH);
    ea   = {{XLEN{a_sg & a[XLEN-1]}}, a};
    eb   = {{XLEN{b_sg & b[XLEN-1]}}, b};
    p    = ea * eb;
    pw   = a[31:0] * b[31:0];
    case (op)
      OP_MUL:                       return p[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
      OP_MULW:                      return sext32(pw);
      default:                      return {XLEN{1'b0}};
    endcase
  endfunction

  logic [1:0]      state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            rsel_q, rsel_d;
  logic            wsel_q, wsel_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            dec_mul_s, dec_div_s, dec_w_s, dec_sgn_s, dec_rem_s;
  logic            a_sign_s, b_sign_s, dz_s, ovf_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, a_ext_s, special_res_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] rem_n_s, quo_n_s, q_fix_s, r_fix_s, sel_s, div_fin_s;
  logic            q_bit_s;

  // Opcode decode of the incoming request.
  always_comb begin
    dec_mul_s = 1'b0;
    dec_div_s = 1'b0;
    dec_w_s   = 1'b0;
    dec_sgn_s = 1'b0;
    dec_rem_s = 1'b0;
    case (i_alu_control)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: dec_mul_s = 1'b1;
      OP_MULW:  dec_mul_s = W_OK;
      OP_DIV:   begin dec_div_s = 1'b1; dec_sgn_s = 1'b1; end
      OP_DIVU:  dec_div_s = 1'b1;
      OP_REM:   begin dec_div_s = 1'b1; dec_sgn_s = 1'b1; dec_rem_s = 1'b1; end
      OP_REMU:  begin dec_div_s = 1'b1; dec_rem_s = 1'b1; end
      OP_DIVW:  begin dec_div_s = W_OK; dec_w_s = 1'b1; dec_sgn_s = 1'b1; end
      OP_DIVUW: begin dec_div_s = W_OK; dec_w_s = 1'b1; end
      OP_REMW:  begin dec_div_s = W_OK; dec_w_s = 1'b1; dec_sgn_s = 1'b1; dec_rem_s = 1'b1; end
      OP_REMUW: begin dec_div_s = W_OK; dec_w_s = 1'b1; dec_rem_s = 1'b1; end
      default:  dec_mul_s = 1'b0;
    endcase
  end

  // Divide operand magnitudes and the one-cycle special results.
  always_comb begin
    if (dec_w_s) begin
      a_sign_s = dec_sgn_s & i_src_a[31];
      b_sign_s = dec_sgn_s & i_src_b[31];
      // W dividends are pre-shifted to the top so the same MSB-first datapath runs 32 steps.
      a_mag_s  = XLEN'(a_sign_s ? 32'(-i_src_a[31:0]) : i_src_a[31:0]) << (XLEN - 32);
      b_mag_s  = XLEN'(b_sign_s ? 32'(-i_src_b[31:0]) : i_src_b[31:0]);
      dz_s     = (i_src_b[31:0] == 32'd0);
      ovf_s    = dec_sgn_s & (i_src_a[31:0] == 32'h8000_0000) & (i_src_b[31:0] == 32'hFFFF_FFFF);
      a_ext_s  = sext32(i_src_a[31:0]);
    end else begin
      a_sign_s = dec_sgn_s & i_src_a[XLEN-1];
      b_sign_s = dec_sgn_s & i_src_b[XLEN-1];
      a_mag_s  = a_sign_s ? -i_src_a : i_src_a;
      b_mag_s  = b_sign_s ? -i_src_b : i_src_b;
      dz_s     = (i_src_b == {XLEN{1'b0}});
      ovf_s    = dec_sgn_s & (i_src_a == MOST_NEG) & (i_src_b == {XLEN{1'b1}});
      a_ext_s  = i_src_a;
    end
    if (dz_s) begin
      special_res_s = dec_rem_s ? a_ext_s : {XLEN{1'b1}};
    end else if (ovf_s) begin
      special_res_s = dec_rem_s ? {XLEN{1'b0}} : a_ext_s;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
  end

  // One restoring-division step plus sign fix-up for the final step.
  always_comb begin
    trial_s = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
    if (!trial_s[XLEN]) begin
      rem_n_s = trial_s[XLEN-1:0];
      q_bit_s = 1'b1;
    end else begin
      rem_n_s = {rem_q[XLEN-2:0], a_q[XLEN-1]};
      q_bit_s = 1'b0;
    end
    quo_n_s   = {a_q[XLEN-2:0], q_bit_s};
    q_fix_s   = qneg_q ? -quo_n_s : quo_n_s;
    r_fix_s   = rneg_q ? -rem_n_s : rem_n_s;
    sel_s     = rsel_q ? r_fix_s : q_fix_s;
    div_fin_s = wsel_q ? sext32(sel_s[31:0]) : sel_s;
  end

  // Control FSM and next-state datapath; kill overrides accept and transfer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rsel_d   = rsel_q;
    wsel_d   = wsel_q;
    valid_d  = valid_q;
    result_d = result_q;
    if (i_kill) begin
      state_d  = S_IDLE;
      cnt_d    = 7'd0;
      valid_d  = 1'b0;
      result_d = {XLEN{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_d = i_alu_control;
            if (dec_mul_s) begin
              a_d = i_src_a;
              b_d = i_src_b;
              if (MUL_SINGLE) begin
                state_d  = S_DONE;
                valid_d  = 1'b1;
                result_d = mul_calc(i_alu_control, i_src_a, i_src_b);
              end else begin
                state_d = S_MUL;
                cnt_d   = MUL_INIT;
              end
            end else if (dec_div_s && (dz_s || ovf_s)) begin
              state_d  = S_DONE;
              valid_d  = 1'b1;
              result_d = special_res_s;
            end else if (dec_div_s) begin
              state_d = S_DIV;
              cnt_d   = dec_w_s ? DIV_CNT_W : DIV_CNT_X;
              a_d     = a_mag_s;
              b_d     = b_mag_s;
              rem_d   = {XLEN{1'b0}};
              qneg_d  = a_sign_s ^ b_sign_s;
              rneg_d  = a_sign_s;
              rsel_d  = dec_rem_s;
              wsel_d  = dec_w_s;
            end else begin
              state_d  = S_DONE;
              valid_d  = 1'b1;
              result_d = {XLEN{1'b0}};
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          if (cnt_q == 7'd0) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = mul_calc(op_q, a_q, b_q);
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        S_DIV: begin
          a_d   = quo_n_s;
          rem_d = rem_n_s;
          if (cnt_q == 7'd0) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = div_fin_s;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            result_d = {XLEN{1'b0}};
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          valid_d  = 1'b0;
          result_d = {XLEN{1'b0}};
        end
      endcase
    end
    ready_d = (state_d == S_IDLE);
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 7'd0;
      op_q     <= 5'd0;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rsel_q   <= 1'b0;
      wsel_q   <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rsel_q   <= rsel_d;
      wsel_q   <= wsel_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_mul_div_unit;

  localparam int XLEN       = 64;
  localparam int MUL_CYCLES = 3;

  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_MULH   = 5'b10000;
  localparam logic [4:0] OP_MULHSU = 5'b10001;
  localparam logic [4:0] OP_MULHU  = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b10011;
  localparam logic [4:0] OP_DIVU   = 5'b10100;
  localparam logic [4:0] OP_REM    = 5'b10101;
  localparam logic [4:0] OP_REMU   = 5'b10110;
  localparam logic [4:0] OP_MULW   = 5'b10111;
  localparam logic [4:0] OP_DIVW   = 5'b11000;
  localparam logic [4:0] OP_DIVUW  = 5'b11001;
  localparam logic [4:0] OP_REMW   = 5'b11010;
  localparam logic [4:0] OP_REMUW  = 5'b11011;
  localparam logic [63:0] MIN64    = 64'h8000_0000_0000_0000;

  logic        i_clk;
  logic        i_arstn;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_alu_control;
  logic [63:0] i_src_a;
  logic [63:0] i_src_b;
  logic        i_kill;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_result;

  int n_checks = 0;
  int n_errors = 0;

  mul_div_unit #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .i_clk         (i_clk),
    .i_arstn       (i_arstn),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_alu_control (i_alu_control),
    .i_src_a       (i_src_a),
    .i_src_b       (i_src_b),
    .i_kill        (i_kill),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_result      (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural reference: plain arithmetic on the operand values.
  function automatic logic [63:0] ref_res(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    longint             sa, sb;
    int                 sa32, sb32;
    logic [31:0]        ua32, ub32;
    logic signed [129:0] x, y, p;
    logic               ovf64, ovf32;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    ovf64 = (a == MIN64) && (b == '1);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    return a * b;
      OP_MULH:   begin x = sa; y = sb; p = x * y; return p[127:64]; end
      OP_MULHSU: begin x = sa; y = {66'd0, b}; p = x * y; return p[127:64]; end
      OP_MULHU:  begin x = {66'd0, a}; y = {66'd0, b}; p = x * y; return p[127:64]; end
      OP_MULW:   return sx32(ua32 * ub32);
      OP_DIV:    return (b == 64'd0) ? '1 : ovf64 ? a : 64'(sa / sb);
      OP_DIVU:   return (b == 64'd0) ? '1 : a / b;
      OP_REM:    return (b == 64'd0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
      OP_REMU:   return (b == 64'd0) ? a : a % b;
      OP_DIVW:   return (ub32 == 32'd0) ? '1 : ovf32 ? sx32(ua32) : sx32(32'(sa32 / sb32));
      OP_DIVUW:  return (ub32 == 32'd0) ? '1 : sx32(ua32 / ub32);
      OP_REMW:   return (ub32 == 32'd0) ? sx32(ua32) : ovf32 ? 64'd0 : sx32(32'(sa32 % sb32));
      OP_REMUW:  return (ub32 == 32'd0) ? sx32(ua32) : sx32(ua32 % ub32);
      default:   return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic z64, z32, ovf64, ovf32;
    z64   = (b == 64'd0);
    z32   = (b[31:0] == 32'd0);
    ovf64 = (a == MIN64) && (b == '1);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW: return MUL_CYCLES;
      OP_DIV, OP_REM:     return (z64 || ovf64) ? 1 : 65;
      OP_DIVU, OP_REMU:   return z64 ? 1 : 65;
      OP_DIVW, OP_REMW:   return (z32 || ovf32) ? 1 : 33;
      OP_DIVUW, OP_REMUW: return z32 ? 1 : 33;
      default:            return 1;
    endcase
  endfunction

  // Caller is at a negedge with the unit idle; returns at a negedge after the result transfer.
  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b, input int hold,
                        output logic [63:0] res, output int lat);
    int c;
    check_val("ready_before_accept", 64'(o_ready), 64'd1);
    i_valid = 1'b1; i_alu_control = op; i_src_a = a; i_src_b = b; i_ready = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0; i_alu_control = 5'($urandom); i_src_a = {$urandom, $urandom}; i_src_b = {$urandom, $urandom};
    c = 1;
    while (!o_valid && c < 200) begin
      @(negedge i_clk);
      c++;
    end
    lat = c;
    res = o_result;
    check_val("valid_seen", 64'(o_valid), 64'd1);
    check_val("ready_in_done", 64'(o_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      check_val("hold_result", o_result, res);
      check_val("hold_valid", 64'(o_valid), 64'd1);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check_val("xfer_valid", 64'(o_valid), 64'd0);
    check_val("xfer_result", o_result, 64'd0);
    check_val("xfer_ready", 64'(o_ready), 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int hold, input logic [63:0] exp_res, input int exp_lat);
    logic [63:0] res;
    int          lat;
    run_op(op, a, b, hold, res, lat);
    check_val({tag, "_res"}, res, exp_res);
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  logic [4:0] ops [15] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                           OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW, 5'b00000, 5'b11111};

  initial begin
    logic [4:0]  op;
    logic [63:0] a, b;
    i_arstn = 1'b0; i_valid = 1'b0; i_alu_control = 5'd0; i_src_a = 64'd0; i_src_b = 64'd0;
    i_kill = 1'b0; i_ready = 1'b0;
    #12;
    check_val("rst_valid", 64'(o_valid), 64'd0);
    check_val("rst_ready", 64'(o_ready), 64'd1);
    check_val("rst_result", o_result, 64'd0);
    @(negedge i_clk);
    i_arstn = 1'b1;
    @(negedge i_clk);

    do_op("div_m7_2", OP_DIV, -64'sd7, 64'sd2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem_m7_2", OP_REM, -64'sd7, 64'sd2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("divu_by0", OP_DIVU, 64'h1234, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("remu_by0", OP_REMU, 64'h1234, 64'd0, 0, 64'h1234, 1);
    do_op("div_ovf", OP_DIV, MIN64, '1, 0, MIN64, 1);
    do_op("rem_ovf", OP_REM, MIN64, '1, 0, 64'd0, 1);
    do_op("mulhu_ff", OP_MULHU, '1, '1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    do_op("mulh_ff", OP_MULH, '1, '1, 0, 64'd0, 3);
    do_op("mulw", OP_MULW, 64'h10000, 64'h8000, 0, 64'hFFFF_FFFF_8000_0000, 3);
    do_op("divw", OP_DIVW, 64'hFFFF_FFFF_8000_0000, 64'd2, 5, 64'hFFFF_FFFF_C000_0000, 33);
    do_op("unsup", 5'b00000, 64'd55, 64'd3, 0, 64'd0, 1);

    // Kill a 64-bit DIV at cycle 10, then immediately run a MUL.
    i_valid = 1'b1; i_alu_control = OP_DIV; i_src_a = 64'd1000; i_src_b = 64'd7;
    @(negedge i_clk);
    i_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      check_val("kill_no_valid", 64'(o_valid), 64'd0);
      @(negedge i_clk);
    end
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    check_val("kill_idle_ready", 64'(o_ready), 64'd1);
    check_val("kill_idle_valid", 64'(o_valid), 64'd0);
    do_op("mul_after_kill", OP_MUL, 64'd3, 64'd5, 0, 64'd15, 3);

    // Kill must override a simultaneous accept.
    i_valid = 1'b1; i_kill = 1'b1; i_alu_control = OP_MUL; i_src_a = 64'd2; i_src_b = 64'd2;
    @(negedge i_clk);
    i_valid = 1'b0; i_kill = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_val("kill_accept_ready", 64'(o_ready), 64'd1);
      check_val("kill_accept_valid", 64'(o_valid), 64'd0);
      @(negedge i_clk);
    end

    // Kill in DONE discards the result even with i_ready high.
    i_valid = 1'b1; i_alu_control = OP_MUL; i_src_a = 64'd6; i_src_b = 64'd7;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (MUL_CYCLES - 1) @(negedge i_clk);
    check_val("done_before_kill", o_result, 64'd42);
    i_kill = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0; i_ready = 1'b0;
    check_val("kill_done_valid", 64'(o_valid), 64'd0);
    check_val("kill_done_result", o_result, 64'd0);

    // Asynchronous reset while a result is waiting.
    i_valid = 1'b1; i_alu_control = OP_MUL; i_src_a = 64'd9; i_src_b = 64'd9;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (MUL_CYCLES - 1) @(negedge i_clk);
    check_val("done_before_rst", o_result, 64'd81);
    #2 i_arstn = 1'b0;
    #1;
    check_val("async_rst_valid", 64'(o_valid), 64'd0);
    check_val("async_rst_ready", 64'(o_ready), 64'd1);
    check_val("async_rst_result", o_result, 64'd0);
    @(negedge i_clk);
    i_arstn = 1'b1;
    @(negedge i_clk);
    do_op("mul_after_rst", OP_MULHSU, '1, 64'd2, 0, '1, 3);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 14)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        1: begin a = {{56{a[7]}}, a[7:0]}; b = {{60{b[3]}}, b[3:0]}; end
        2: b = ($urandom_range(0, 1) == 0) ? 64'd0 : {b[63:32], 32'd0};
        3: begin a = ($urandom_range(0, 1) == 0) ? MIN64 : 64'hFFFF_FFFF_8000_0000; b = '1; end
        4: b = {32'd0, 16'd0, b[15:0]};
        default: b = b;
      endcase
      do_op($sformatf("rand%0d", i), op, a, b, $urandom_range(0, 2), ref_res(op, a, b), ref_lat(op, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
